// File: rtl/imem_access_arbiter_if.sv
// Bus bundle between the fetch stage, program loader, instruction memory and the arbiter.
// The arbiter takes the slave view; the surrounding environment takes the master view.
interface imem_access_arbiter_if #(
  parameter int unsigned ADDR_W = 32
) ();
  logic              f_req;
  logic [ADDR_W-1:0] f_addr;
  logic              f_gnt;
  logic              f_rvalid;
  logic [31:0]       f_rdata;
  logic              f_err;

  logic              l_req;
  logic              l_we;
  logic [ADDR_W-1:0] l_addr;
  logic [31:0]       l_wdata;
  logic              l_gnt;
  logic              l_rvalid;
  logic [31:0]       l_rdata;
  logic              l_err;
  logic              l_boot_done;

  logic              core_hold;

  logic              m_en;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [31:0]       m_wdata;
  logic [31:0]       m_rdata;

  modport slave (
    input  f_req, f_addr, l_req, l_we, l_addr, l_wdata, l_boot_done, m_rdata,
    output f_gnt, f_rvalid, f_rdata, f_err, l_gnt, l_rvalid, l_rdata, l_err,
    output core_hold, m_en, m_we, m_addr, m_wdata
  );

  modport master (
    output f_req, f_addr, l_req, l_we, l_addr, l_wdata, l_boot_done, m_rdata,
    input  f_gnt, f_rvalid, f_rdata, f_err, l_gnt, l_rvalid, l_rdata, l_err,
    input  core_hold, m_en, m_we, m_addr, m_wdata
  );
endinterface

// File: rtl/imem_access_arbiter.sv
// Shares a single-port instruction memory between core fetch and the loader, holding the core
// until boot completes. Define IMEM_ARB_RR_EN for round-robin instead of loader priority.
module imem_access_arbiter #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DEPTH_BYTES = 128,
  parameter int unsigned MAX_L_BURST = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  imem_access_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRespF, StRespL} state_e;

  localparam logic [ADDR_W-1:0] MaxAddr = ADDR_W'(DEPTH_BYTES - 4);

  state_e state_q, state_d;
  logic   core_hold_q, core_hold_d;
  logic   err_q, err_d;
  logic   we_q, we_d;

`ifdef IMEM_ARB_RR_EN
  logic last_f_q, last_f_d;
`else
  localparam int unsigned CntW = $clog2(MAX_L_BURST + 1);
  logic [CntW-1:0] l_consec_q, l_consec_d;
`endif

  logic              f_elig, pick_f, in_idle, gnt_f, gnt_l, any_gnt, win_bad;
  logic [ADDR_W-1:0] win_addr;

  always_comb begin
    f_elig  = bus.f_req & ~core_hold_q;
`ifdef IMEM_ARB_RR_EN
    pick_f  = f_elig & (~bus.l_req | ~last_f_q);
`else
    pick_f  = f_elig & (~bus.l_req | (l_consec_q == CntW'(MAX_L_BURST)));
`endif
    // Gating with rst_n keeps grants at their reset value while reset is held.
    in_idle = (state_q == StIdle) & rst_n;
    gnt_f   = in_idle & pick_f;
    gnt_l   = in_idle & bus.l_req & ~pick_f;
    any_gnt = gnt_f | gnt_l;

    win_addr = '0;
    if (gnt_f) begin
      win_addr = bus.f_addr;
    end else if (gnt_l) begin
      win_addr = bus.l_addr;
    end
    win_bad = (win_addr[1:0] != 2'b00) || (win_addr > MaxAddr);

    bus.f_gnt   = gnt_f;
    bus.l_gnt   = gnt_l;
    bus.m_en    = any_gnt & ~win_bad;
    bus.m_we    = gnt_l & bus.l_we & ~win_bad;
    bus.m_addr  = win_addr;
    bus.m_wdata = gnt_l ? bus.l_wdata : 32'h0;

    state_d     = gnt_f ? StRespF : (gnt_l ? StRespL : StIdle);
    err_d       = any_gnt & win_bad;
    we_d        = gnt_l & bus.l_we;
    core_hold_d = core_hold_q & ~bus.l_boot_done;

`ifdef IMEM_ARB_RR_EN
    last_f_d = last_f_q;
    if (gnt_f) begin
      last_f_d = 1'b1;
    end else if (gnt_l) begin
      last_f_d = 1'b0;
    end
`else
    l_consec_d = l_consec_q;
    if (gnt_f) begin
      l_consec_d = '0;
    end else if (gnt_l) begin
      if (!f_elig) begin
        l_consec_d = '0;
      end else if (l_consec_q != CntW'(MAX_L_BURST)) begin
        l_consec_d = l_consec_q + 1'b1;
      end
    end
`endif

    // Responses decode from registered state; rdata passes the array's 1-cycle read through.
    bus.f_rvalid  = (state_q == StRespF);
    bus.f_err     = bus.f_rvalid & err_q;
    bus.f_rdata   = (bus.f_rvalid & ~err_q) ? bus.m_rdata : 32'h0;
    bus.l_rvalid  = (state_q == StRespL);
    bus.l_err     = bus.l_rvalid & err_q;
    bus.l_rdata   = (bus.l_rvalid & ~err_q & ~we_q) ? bus.m_rdata : 32'h0;
    bus.core_hold = core_hold_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      core_hold_q <= 1'b1;
      err_q       <= 1'b0;
      we_q        <= 1'b0;
`ifdef IMEM_ARB_RR_EN
      last_f_q    <= 1'b1;
`else
      l_consec_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      core_hold_q <= core_hold_d;
      err_q       <= err_d;
      we_q        <= we_d;
`ifdef IMEM_ARB_RR_EN
      last_f_q    <= last_f_d;
`else
      l_consec_q  <= l_consec_d;
`endif
    end
  end

endmodule

// File: tb/tb_imem_access_arbiter.sv
// Directed plus randomized bench for imem_access_arbiter against a spec-level reference model
// (word array, boot flag, grant-order rule). Honours IMEM_ARB_RR_EN like the design.
module tb_imem_access_arbiter;

  localparam int unsigned MaxLBurst = 4;
  localparam int unsigned Depth     = 128;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  imem_access_arbiter_if #(.ADDR_W(32)) bus ();

  imem_access_arbiter #(
    .ADDR_W     (32),
    .DEPTH_BYTES(Depth),
    .MAX_L_BURST(MaxLBurst)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory array: synchronous 1-cycle read, word indexed by byte address.
  logic [31:0] mem [Depth/4];
  always @(posedge clk) begin
    if (bus.m_en) begin
      if (bus.m_we) mem[bus.m_addr[6:2]] <= bus.m_wdata;
      else          bus.m_rdata <= mem[bus.m_addr[6:2]];
    end
  end

  // Reference model state
  logic [31:0] ref_mem [Depth/4];
  bit          ref_hold;
  int          ref_consec;
  bit          ref_last_f;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic bit is_bad(input logic [31:0] a);
    return (a % 4 != 0) || (a > Depth - 4);
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'(a / 4) % (Depth / 4);
  endfunction

  task automatic model_reset();
    ref_hold   = 1'b1;
    ref_consec = 0;
    ref_last_f = 1'b1;
  endtask

  // Expected winner when both requesters are eligible.
  function automatic bit tie_goes_to_fetch();
`ifdef IMEM_ARB_RR_EN
    return !ref_last_f;
`else
    return ref_consec >= MaxLBurst;
`endif
  endfunction

  task automatic note_grant(input bit fetch_won, input bit fetch_waiting);
    ref_last_f = fetch_won;
    if (fetch_won || !fetch_waiting) ref_consec = 0;
    else if (ref_consec < MaxLBurst) ref_consec++;
  endtask

  task automatic wait_gnt(input bit fetch);
    int n = 0;
    @(negedge clk);
    while (((fetch ? bus.f_gnt : bus.l_gnt) !== 1'b1) && n < 8) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic loader_op(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                           input bit pulse_boot);
    bit bad = is_bad(addr);
    bus.l_req = 1'b1; bus.l_we = we; bus.l_addr = addr; bus.l_wdata = wdata;
    wait_gnt(1'b0);
    chk("l_gnt", {31'b0, bus.l_gnt}, 32'd1);
    chk("l_m_en", {31'b0, bus.m_en}, {31'b0, !bad});
    chk("l_m_we", {31'b0, bus.m_we}, {31'b0, we && !bad});
    if (!bad) chk("l_m_addr", bus.m_addr, addr);
    note_grant(1'b0, 1'b0);
    @(posedge clk); #1;
    bus.l_req = 1'b0;
    if (pulse_boot) bus.l_boot_done = 1'b1;
    @(negedge clk);
    chk("l_rvalid", {31'b0, bus.l_rvalid}, 32'd1);
    chk("l_err", {31'b0, bus.l_err}, {31'b0, bad});
    chk("l_rdata", bus.l_rdata, (bad || we) ? 32'h0 : ref_mem[widx(addr)]);
    if (we && !bad) ref_mem[widx(addr)] = wdata;
    @(posedge clk); #1;
    if (pulse_boot) begin
      bus.l_boot_done = 1'b0;
      ref_hold = 1'b0;
    end
  endtask

  task automatic fetch_op(input logic [31:0] addr);
    bit bad = is_bad(addr);
    bus.f_req = 1'b1; bus.f_addr = addr;
    wait_gnt(1'b1);
    chk("f_gnt", {31'b0, bus.f_gnt}, 32'd1);
    chk("f_m_en", {31'b0, bus.m_en}, {31'b0, !bad});
    chk("f_m_we", {31'b0, bus.m_we}, 32'd0);
    note_grant(1'b1, 1'b1);
    @(posedge clk); #1;
    bus.f_req = 1'b0;
    @(negedge clk);
    chk("f_rvalid", {31'b0, bus.f_rvalid}, 32'd1);
    chk("f_err", {31'b0, bus.f_err}, {31'b0, bad});
    chk("f_rdata", bus.f_rdata, bad ? 32'h0 : ref_mem[widx(addr)]);
    @(posedge clk); #1;
  endtask

  task automatic contend(input int grants);
    bit exp_f;
    for (int g = 0; g < grants; g++) begin
      bus.f_req = 1'b1; bus.f_addr = 32'($urandom_range(0, Depth / 4 - 1) * 4);
      bus.l_req = 1'b1; bus.l_we = 1'b0;
      bus.l_addr = 32'($urandom_range(0, Depth / 4 - 1) * 4);
      @(negedge clk);
      exp_f = tie_goes_to_fetch();
      chk("cont_f_gnt", {31'b0, bus.f_gnt}, {31'b0, exp_f});
      chk("cont_l_gnt", {31'b0, bus.l_gnt}, {31'b0, !exp_f});
      note_grant(exp_f, 1'b1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("cont_rvalid", {30'b0, bus.f_rvalid, bus.l_rvalid}, exp_f ? 32'd2 : 32'd1);
      chk("cont_rdata", exp_f ? bus.f_rdata : bus.l_rdata,
          ref_mem[widx(exp_f ? bus.f_addr : bus.l_addr)]);
      @(posedge clk); #1;
    end
    bus.f_req = 1'b0;
    bus.l_req = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    int          op;
    vectors = 0;
    miscompares = 0;
    model_reset();
    bus.f_req = 1'b0; bus.f_addr = '0;
    bus.l_req = 1'b1; bus.l_we = 1'b1; bus.l_addr = '0; bus.l_wdata = 32'h0;
    bus.l_boot_done = 1'b0;
    rst_n = 1'b0;

    // Reset values, with a loader request pending that must not be granted
    #12;
    chk("rst_l_gnt", {31'b0, bus.l_gnt}, 32'd0);
    chk("rst_m_en", {30'b0, bus.m_en, bus.m_we}, 32'd0);
    chk("rst_rvalid", {30'b0, bus.f_rvalid, bus.l_rvalid}, 32'd0);
    chk("rst_err", {30'b0, bus.f_err, bus.l_err}, 32'd0);
    chk("rst_rdata", bus.f_rdata | bus.l_rdata, 32'd0);
    chk("rst_core_hold", {31'b0, bus.core_hold}, 32'd1);
    bus.l_req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Boot hold: fetch ignored
    bus.f_req = 1'b1; bus.f_addr = 32'd0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_f_gnt", {31'b0, bus.f_gnt}, 32'd0);
      chk("hold_core_hold", {31'b0, bus.core_hold}, {31'b0, ref_hold});
    end
    @(posedge clk); #1;
    bus.f_req = 1'b0;

    loader_op(1'b1, 32'd0, 32'h0000_0013, 1'b0);
    loader_op(1'b1, 32'd4, 32'h0000_0013, 1'b0);
    loader_op(1'b1, 32'd8, 32'h0000_0013, 1'b0);
    for (int i = 3; i < int'(Depth / 4); i++) loader_op(1'b1, 32'(i * 4), $urandom, 1'b0);
    loader_op(1'b0, 32'd8, 32'h0, 1'b0);

    // Boot done pulse
    bus.l_boot_done = 1'b1;
    @(negedge clk);
    chk("boot_edge_hold", {31'b0, bus.core_hold}, 32'd1);
    @(posedge clk); #1;
    bus.l_boot_done = 1'b0;
    ref_hold = 1'b0;
    @(negedge clk);
    chk("boot_core_hold", {31'b0, bus.core_hold}, {31'b0, ref_hold});
    @(posedge clk); #1;

    fetch_op(32'd4);
    fetch_op(32'd6);
    loader_op(1'b1, 32'd128, 32'hDEAD_BEEF, 1'b0);
    loader_op(1'b1, 32'd124, 32'hCAFE_F00D, 1'b0);
    fetch_op(32'd124);
    fetch_op(32'd128);

    contend(10);
    fetch_op(32'd0);
    contend(6);

    // Randomized mix, some illegal addresses
    for (int i = 0; i < 40; i++) begin
      op = int'($urandom_range(0, 2));
      a  = ($urandom_range(0, 5) == 0) ? 32'($urandom_range(0, 255))
                                       : 32'($urandom_range(0, Depth / 4 - 1) * 4);
      if (op == 0)      loader_op(1'b1, a, $urandom, 1'b0);
      else if (op == 1) loader_op(1'b0, a, 32'h0, 1'b0);
      else              fetch_op(a);
    end
    for (int i = 0; i < int'(Depth / 4); i++) fetch_op(32'(i * 4));

    // Reset during a loader response
    bus.l_req = 1'b1; bus.l_we = 1'b0; bus.l_addr = 32'd16;
    wait_gnt(1'b0);
    chk("mid_l_gnt", {31'b0, bus.l_gnt}, 32'd1);
    @(posedge clk); #1;
    bus.l_req = 1'b0;
    #2;
    chk("mid_l_rvalid_pre", {31'b0, bus.l_rvalid}, 32'd1);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("mid_l_rvalid_rst", {31'b0, bus.l_rvalid}, 32'd0);
    chk("mid_l_rdata_rst", bus.l_rdata, 32'd0);
    chk("mid_core_hold", {31'b0, bus.core_hold}, {31'b0, ref_hold});
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.f_req = 1'b1; bus.f_addr = 32'd0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rehold_f_gnt", {31'b0, bus.f_gnt}, 32'd0);
    end
    @(posedge clk); #1;
    bus.f_req = 1'b0;

    // Boot pulse landing in a loader response leaves that response intact
    loader_op(1'b0, 32'd20, 32'h0, 1'b1);
    @(negedge clk);
    chk("reboot_core_hold", {31'b0, bus.core_hold}, {31'b0, ref_hold});
    @(posedge clk); #1;
    fetch_op(32'd20);
    contend(5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
